// File: rtl/dsa_engine_pkg.sv
// Shared constants for the DSA command engine: opcodes, FSM states,
// RD selectors and command-word field positions.
package dsa_engine_pkg;

    localparam logic [1:0] OP_CLR = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] RD_SEL_ACC       = 2'd0;
    localparam logic [1:0] RD_SEL_CMD_CNT   = 2'd1;
    localparam logic [1:0] RD_SEL_STALL_CNT = 2'd2;
    localparam logic [1:0] RD_SEL_ZERO      = 2'd3;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 30;
    localparam int RSVD_MSB = 29;
    localparam int RSVD_LSB = 16;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;

endpackage

// File: rtl/dsa_cmd_engine_if.sv
// Command-FIFO / response-FIFO handshake bundle of one DSA queue slot.
interface dsa_cmd_engine_if;
    logic [31:0] dsa_cmd_buffer;
    logic        empty_cmd;
    logic        rd_en_cmd;
    logic        full_rsp;
    logic        wr_en_rsp;
    logic [31:0] dsa_rsp_buffer;
    logic        busy;

    // master: the FIFO side; slave: the engine
    modport master (
        output dsa_cmd_buffer, empty_cmd, full_rsp,
        input  rd_en_cmd, wr_en_rsp, dsa_rsp_buffer, busy
    );
    modport slave (
        input  dsa_cmd_buffer, empty_cmd, full_rsp,
        output rd_en_cmd, wr_en_rsp, dsa_rsp_buffer, busy
    );
endinterface

// File: rtl/dsa_seq_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, MUL_BITS
// iterations in total; done pulses once when p holds the final product.
module dsa_seq_mul
    import dsa_engine_pkg::*;
#(
    parameter int MUL_BITS = 16
) (
    input  logic        dsa_clk,
    input  logic        dsa_rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        done,
    output logic [31:0] p
);
    localparam int CW = $clog2(MUL_BITS + 1);

    logic [31:0]   mcand;
    logic [15:0]   mplier;
    logic [CW-1:0] cnt;

    // The first iteration is folded into the load so the product is ready
    // MUL_BITS cycles after start, which keeps the engine's MUL latency exact.
    always_ff @(posedge dsa_clk or posedge dsa_rst) begin
        if (dsa_rst) begin
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            p      <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                p      <= b[0] ? {16'b0, a} : 32'b0;
                mcand  <= {15'b0, a, 1'b0};
                mplier <= {1'b0, b[15:1]};
                cnt    <= CW'(MUL_BITS - 1);
                done   <= (MUL_BITS == 1);
            end else if (cnt != '0) begin
                if (mplier[0]) p <= p + mcand;
                mcand  <= {mcand[30:0], 1'b0};
                mplier <= {1'b0, mplier[15:1]};
                cnt    <= cnt - CW'(1);
                done   <= (cnt == CW'(1));
            end
        end
    end
endmodule

// File: rtl/dsa_cmd_engine.sv
// Per-queue DSA command engine: pops commands, runs them on a 32-bit
// accumulator, pushes one response each. DSA_ENGINE_PERF_EN adds perf counters.
module dsa_cmd_engine
    import dsa_engine_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int MUL_BITS  = 16
) (
    input logic             dsa_clk,
    input logic             dsa_rst,
    dsa_cmd_engine_if.slave q
);
    state_t      state;
    logic [1:0]  op_q;
    logic [15:0] imm_q;
    logic [31:0] acc;
    logic [31:0] result_q;
    logic [31:0] add_sum;
    logic [31:0] rd_val;
    logic [31:0] mul_p;
    logic        mul_done;
    logic        pop;
    logic [1:0]  head_op;
    logic [15:0] head_imm;
    logic        unused_rsvd;

    assign head_op     = q.dsa_cmd_buffer[OP_MSB:OP_LSB];
    assign head_imm    = q.dsa_cmd_buffer[IMM_MSB:IMM_LSB];
    assign unused_rsvd = ^q.dsa_cmd_buffer[RSVD_MSB:RSVD_LSB];

    assign pop              = (state == ST_IDLE) & ~q.empty_cmd & ~dsa_rst;
    assign q.rd_en_cmd      = pop;
    assign q.wr_en_rsp      = (state == ST_RESP) & ~q.full_rsp;
    assign q.dsa_rsp_buffer = result_q;
    assign q.busy           = (state != ST_IDLE);
    assign add_sum          = acc + 32'(imm_q);

    // Multiplier is launched from the FIFO head in the pop cycle.
    dsa_seq_mul #(.MUL_BITS(MUL_BITS)) u_mul (
        .dsa_clk (dsa_clk),
        .dsa_rst (dsa_rst),
        .start   (pop && head_op == OP_MUL),
        .a       (acc[15:0]),
        .b       (head_imm),
        .done    (mul_done),
        .p       (mul_p)
    );

`ifdef DSA_ENGINE_PERF_EN
    logic [CNT_WIDTH-1:0] cmd_cnt;
    logic [CNT_WIDTH-1:0] stall_cnt;

    always_ff @(posedge dsa_clk or posedge dsa_rst) begin
        if (dsa_rst) begin
            cmd_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop) cmd_cnt <= cmd_cnt + CNT_WIDTH'(1);
            if (state == ST_RESP && q.full_rsp) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        rd_val = acc;
        case (imm_q[1:0])
            RD_SEL_ACC:       rd_val = acc;
            RD_SEL_CMD_CNT:   rd_val = 32'(cmd_cnt);
            RD_SEL_STALL_CNT: rd_val = 32'(stall_cnt);
            RD_SEL_ZERO:      rd_val = 32'b0;
            default:          rd_val = acc;
        endcase
    end
`else
    assign rd_val = acc;
`endif

    always_ff @(posedge dsa_clk or posedge dsa_rst) begin
        if (dsa_rst) begin
            state    <= ST_IDLE;
            op_q     <= OP_CLR;
            imm_q    <= '0;
            acc      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (pop) begin
                    op_q  <= head_op;
                    imm_q <= head_imm;
                    state <= ST_EXEC;
                end
                ST_EXEC: case (op_q)
                    OP_CLR: begin
                        acc      <= '0;
                        result_q <= '0;
                        state    <= ST_RESP;
                    end
                    OP_ADD: begin
                        acc      <= add_sum;
                        result_q <= add_sum;
                        state    <= ST_RESP;
                    end
                    OP_MUL: if (mul_done) begin
                        acc      <= mul_p;
                        result_q <= mul_p;
                        state    <= ST_RESP;
                    end
                    default: begin
                        result_q <= rd_val;
                        state    <= ST_RESP;
                    end
                endcase
                ST_RESP: if (!q.full_rsp) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
